// File: rtl/bilateral_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bilateral_pkg
// Description : Shared defaults, types and FSM encoding for the bilateral-filter
//               scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bilateral_pkg;

    localparam int DEF_IMG_W    = 256;
    localparam int DEF_IMG_H    = 256;
    localparam int DEF_RADIUS   = 5;
    localparam int DEF_CORE_LAT = 8;
    localparam int DEF_ADDR_W   = 16;
    localparam int PIX_W        = 8;
    localparam int TAG_W        = 8;
    localparam int CNT_W        = 20;

    typedef logic [PIX_W-1:0]      pixel_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bilateral_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bilateral_delay_pipe
// Description : Fixed-depth valid + payload shift register with synchronous
//               clear; pending_o flags entries not yet at the output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bilateral_delay_pipe
    import bilateral_pkg::*;
#(
    parameter int DEPTH = DEF_CORE_LAT,
    parameter int WIDTH = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

    generate
        if (DEPTH > 1) begin : g_pending
            assign pending_o = |valid_q[DEPTH-2:0];
        end else begin : g_no_pending
            assign pending_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bilateral_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bilateral_scan_ctrl
// Description : Raster-scan sequencer feeding the bilateral core and timing its
//               results back out as interior-pixel writes.
//               Optional cycle counter: define BILATERAL_SCAN_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bilateral_scan_ctrl
    import bilateral_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int RADIUS   = DEF_RADIUS,
    parameter int CORE_LAT = DEF_CORE_LAT,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] in_addr,
    input  pixel_t            in_data,
    output logic              core_pix_valid,
    output pixel_t            core_pix,
    output logic [TAG_W-1:0]  core_row,
    output logic [TAG_W-1:0]  core_col,
    output logic              core_center,
    input  pixel_t            core_res,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output pixel_t            out_data,
    output logic              finish,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [TAG_W-1:0]  COL_LAST = TAG_W'(IMG_W - 1);
    localparam logic [TAG_W-1:0]  EDGE     = TAG_W'(2 * RADIUS);
    localparam logic [ADDR_W-1:0] RAD_A    = ADDR_W'(RADIUS);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  k_q, k_d;
    logic [TAG_W-1:0]   row_q, row_d;
    logic [TAG_W-1:0]   col_q, col_d;
    logic               fv_q;
    logic [TAG_W-1:0]   tag_row_q;
    logic [TAG_W-1:0]   tag_col_q;

    logic               w_fetch;
    logic               w_center;
    logic [ADDR_W-1:0]  w_row_off;
    logic [ADDR_W-1:0]  w_col_off;
    logic [ADDR_W-1:0]  w_centre_addr;
    logic               w_pipe_valid;
    logic [ADDR_W-1:0]  w_pipe_addr;
    logic               w_pipe_pending;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        w_fetch = 1'b0;
        case (state_q)
            IDLE, FETCH: begin
                if (in_valid) begin
                    w_fetch = 1'b1;
                    if (k_q == LAST_K) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FETCH;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            // Done once nothing can still reach the output after this cycle.
            DRAIN: begin
                if (!w_center && !w_pipe_pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (w_fetch) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            fv_q      <= 1'b0;
            tag_row_q <= '0;
            tag_col_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fv_q    <= w_fetch;
            if (w_fetch) begin
                tag_row_q <= row_q;
                tag_col_q <= col_q;
            end
        end
    end

    assign w_center  = fv_q && (tag_row_q >= EDGE) && (tag_col_q >= EDGE);
    assign w_row_off = ADDR_W'(tag_row_q) - RAD_A;
    assign w_col_off = ADDR_W'(tag_col_q) - RAD_A;

    generate
        if (is_pow2(IMG_W)) begin : g_shift
            assign w_centre_addr = (w_row_off << $clog2(IMG_W)) + w_col_off;
        end else begin : g_mult
            assign w_centre_addr = (w_row_off * ADDR_W'(IMG_W)) + w_col_off;
        end
    endgenerate

    bilateral_delay_pipe #(
        .DEPTH (CORE_LAT),
        .WIDTH (ADDR_W)
    ) u_delay_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (w_center),
        .data_i    (w_centre_addr),
        .valid_o   (w_pipe_valid),
        .data_o    (w_pipe_addr),
        .pending_o (w_pipe_pending)
    );

    // Read data returns one cycle after the address, aligned with the fetch tags.
    assign in_addr        = k_q;
    assign core_pix_valid = fv_q;
    assign core_pix       = fv_q ? in_data : '0;
    assign core_row       = tag_row_q;
    assign core_col       = tag_col_q;
    assign core_center    = w_center;
    assign out_valid      = w_pipe_valid;
    assign out_addr       = w_pipe_valid ? w_pipe_addr : '0;
    assign out_data       = w_pipe_valid ? core_res : '0;
    assign finish         = (state_q == DONE);

`ifdef BILATERAL_SCAN_PERF_EN
    logic [CNT_W-1:0] cyc_q;
    logic             cyc_frz_q;

    // Counts through the first DONE cycle, then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q     <= '0;
            cyc_frz_q <= 1'b0;
        end else if ((state_q != IDLE) && !cyc_frz_q) begin
            if (cyc_q != '1) begin
                cyc_q <= cyc_q + 1'b1;
            end
            cyc_frz_q <= (state_q == DONE);
        end
    end

    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bilateral_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bilateral_scan_ctrl
// Description : Directed bench: default 256x256 instance and an 8x8 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bilateral_scan_ctrl;

`ifdef BILATERAL_SCAN_PERF_EN
    localparam int EXP_CC_BIG   = 65545;
    localparam int EXP_CC_SMALL = 67;
    localparam int EXP_CC_PAUSE = 72;
`else
    localparam int EXP_CC_BIG   = 0;
    localparam int EXP_CC_SMALL = 0;
    localparam int EXP_CC_PAUSE = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    // big instance (defaults)
    logic        b_rst, b_in_valid, b_cpv, b_cctr, b_ov, b_fin;
    logic [15:0] b_in_addr, b_oa;
    logic [7:0]  b_in_data, b_cpix, b_crow, b_ccol, b_cres, b_od;
    logic [19:0] b_cc;
    logic [7:0]  b_dl [8];
    // small instance (8x8, R=1, LAT=2)
    logic        s_rst, s_in_valid, s_cpv, s_cctr, s_ov, s_fin;
    logic [15:0] s_in_addr, s_oa;
    logic [7:0]  s_in_data, s_cpix, s_crow, s_ccol, s_cres, s_od;
    logic [19:0] s_cc;
    logic [7:0]  s_dl [2];

    bilateral_scan_ctrl u_big (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_addr(b_in_addr),
        .in_data(b_in_data), .core_pix_valid(b_cpv), .core_pix(b_cpix),
        .core_row(b_crow), .core_col(b_ccol), .core_center(b_cctr),
        .core_res(b_cres), .out_valid(b_ov), .out_addr(b_oa), .out_data(b_od),
        .finish(b_fin), .cycle_cnt(b_cc)
    );

    bilateral_scan_ctrl #(.IMG_W(8), .IMG_H(8), .RADIUS(1), .CORE_LAT(2), .ADDR_W(16)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_addr(s_in_addr),
        .in_data(s_in_data), .core_pix_valid(s_cpv), .core_pix(s_cpix),
        .core_row(s_crow), .core_col(s_ccol), .core_center(s_cctr),
        .core_res(s_cres), .out_valid(s_ov), .out_addr(s_oa), .out_data(s_od),
        .finish(s_fin), .cycle_cnt(s_cc)
    );

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 37) ^ (a >> 8));
    endfunction

    // Image memory with one-cycle read latency; core modelled as a pure delay.
    always @(posedge clk) begin
        b_in_data <= pix(int'(b_in_addr));
        s_in_data <= pix(int'(s_in_addr));
        b_dl[0]   <= b_cpix;
        for (int i = 1; i < 8; i++) b_dl[i] <= b_dl[i-1];
        s_dl[0]   <= s_cpix;
        s_dl[1]   <= s_dl[0];
    end
    assign b_cres = b_dl[7];
    assign s_cres = s_dl[1];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor state, index 0 = big, 1 = small
    bit mon_en [2];
    int wr_cnt [2], nxt_r [2], nxt_c [2], err_a [2], err_d [2], err_t [2];
    int fin_cyc [2], ctr_cnt [2], t0 [2], p_at [2], p_len [2], first_a [2], last_a [2];

    task automatic mon_reset(input int i, input int r, input int pat, input int plen);
        wr_cnt[i] = 0; nxt_r[i] = r; nxt_c[i] = r;
        err_a[i] = 0; err_d[i] = 0; err_t[i] = 0;
        fin_cyc[i] = -1; ctr_cnt[i] = 0; first_a[i] = -1; last_a[i] = -1;
        p_at[i] = pat; p_len[i] = plen; mon_en[i] = 1'b1;
    endtask

    task automatic mon_step(input int i, input int w, input int r, input int lat,
                            input logic ov, input int oa, input int od,
                            input logic ctr, input logic fin);
        int k, ea, ec;
        if (!mon_en[i]) return;
        if (ctr) ctr_cnt[i]++;
        if (ov) begin
            ea = nxt_r[i] * w + nxt_c[i];
            k  = (nxt_r[i] + r) * w + nxt_c[i] + r;
            ec = t0[i] + k + 1 + lat + ((k >= p_at[i]) ? p_len[i] : 0);
            if (oa != ea) err_a[i]++;
            if (od != int'(pix(k))) err_d[i]++;
            if (cyc != ec) err_t[i]++;
            if (wr_cnt[i] == 0) first_a[i] = oa;
            last_a[i] = oa;
            wr_cnt[i]++;
            if (nxt_c[i] == w - r - 1) begin
                nxt_c[i] = r;
                nxt_r[i]++;
            end else begin
                nxt_c[i]++;
            end
        end
        if (fin && fin_cyc[i] < 0) fin_cyc[i] = cyc - t0[i];
    endtask

    always @(negedge clk) begin
        mon_step(0, 256, 5, 8, b_ov, int'(b_oa), int'(b_od), b_cctr, b_fin);
        mon_step(1, 8, 1, 2, s_ov, int'(s_oa), int'(s_od), s_cctr, s_fin);
    end

    task automatic wait_fin(input int i, input int bound);
        for (int n = 0; n < bound; n++) begin
            if ((i == 0) ? b_fin : s_fin) break;
            tick();
        end
        check_eq(i == 0 ? "b_fin_reached" : "s_fin_reached",
                 longint'((i == 0) ? b_fin : s_fin), 1);
        tick();
    endtask

    task automatic post_fin(input int i);
        int bad;
        logic [15:0] a0;
        bad = 0;
        a0  = (i == 0) ? b_in_addr : s_in_addr;
        if (i == 0) b_in_valid = 1'b1; else s_in_valid = 1'b1;
        repeat (20) begin
            tick();
            if ((i == 0) ? b_ov : s_ov) bad++;
            if (((i == 0) ? b_in_addr : s_in_addr) != a0) bad++;
            if (!((i == 0) ? b_fin : s_fin)) bad++;
        end
        check_eq(i == 0 ? "b_post_finish" : "s_post_finish", bad, 0);
    endtask

    initial begin
        int bad;
        mon_en[0] = 1'b0; mon_en[1] = 1'b0;
        b_rst = 1'b1; s_rst = 1'b1; b_in_valid = 1'b0; s_in_valid = 1'b0;
        repeat (3) tick();
        b_rst = 1'b0; s_rst = 1'b0;
        tick();
        check_eq("rst_out_valid", b_ov, 0);
        check_eq("rst_finish", b_fin, 0);
        check_eq("rst_in_addr", b_in_addr, 0);
        check_eq("rst_cycle_cnt", b_cc, 0);
        check_eq("rst_core_pix_valid", b_cpv, 0);
        check_eq("rst_s_finish", s_fin, 0);

        // small image, no pause
        mon_reset(1, 1, 1 << 30, 0);
        s_in_valid = 1'b1;
        t0[1] = cyc;
        wait_fin(1, 200);
        check_eq("s_writes", wr_cnt[1], 36);
        check_eq("s_first_addr", first_a[1], 9);
        check_eq("s_last_addr", last_a[1], 54);
        check_eq("s_addr_err", err_a[1], 0);
        check_eq("s_data_err", err_d[1], 0);
        check_eq("s_time_err", err_t[1], 0);
        check_eq("s_center_cnt", ctr_cnt[1], 36);
        check_eq("s_finish_cycle", fin_cyc[1], 67);
        check_eq("s_cycle_cnt", s_cc, EXP_CC_SMALL);
        post_fin(1);

        // small image, 5-cycle pause before fetch 20
        s_rst = 1'b1; s_in_valid = 1'b0;
        tick();
        s_rst = 1'b0;
        tick();
        check_eq("s_rerst_finish", s_fin, 0);
        mon_reset(1, 1, 20, 5);
        s_in_valid = 1'b1;
        t0[1] = cyc;
        repeat (20) tick();
        s_in_valid = 1'b0;
        bad = 0;
        repeat (5) begin
            if (s_in_addr != 16'd20) bad++;
            tick();
        end
        s_in_valid = 1'b1;
        check_eq("s_pause_addr_hold", bad, 0);
        wait_fin(1, 200);
        check_eq("s_pause_writes", wr_cnt[1], 36);
        check_eq("s_pause_addr_err", err_a[1], 0);
        check_eq("s_pause_data_err", err_d[1], 0);
        check_eq("s_pause_time_err", err_t[1], 0);
        check_eq("s_pause_finish_cycle", fin_cyc[1], 72);
        check_eq("s_pause_cycle_cnt", s_cc, EXP_CC_PAUSE);

        // big image: partial run, mid-run reset, then full frame
        b_in_valid = 1'b1;
        repeat (3000) tick();
        b_rst = 1'b1;
        tick();
        check_eq("mid_rst_out_valid", b_ov, 0);
        check_eq("mid_rst_finish", b_fin, 0);
        check_eq("mid_rst_in_addr", b_in_addr, 0);
        check_eq("mid_rst_core_pix_valid", b_cpv, 0);
        b_rst = 1'b0;
        mon_reset(0, 5, 1 << 30, 0);
        t0[0] = cyc;
        wait_fin(0, 70000);
        check_eq("b_writes", wr_cnt[0], 60516);
        check_eq("b_first_addr", first_a[0], 1285);
        check_eq("b_last_addr", last_a[0], 64250);
        check_eq("b_addr_err", err_a[0], 0);
        check_eq("b_data_err", err_d[0], 0);
        check_eq("b_time_err", err_t[0], 0);
        check_eq("b_center_cnt", ctr_cnt[0], 60516);
        check_eq("b_finish_cycle", fin_cyc[0], 65545);
        check_eq("b_cycle_cnt", b_cc, EXP_CC_BIG);
        post_fin(0);
        check_eq("b_writes_after_idle", wr_cnt[0], 60516);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
